// File: rtl/psa_16bit.sv
// psa_16bit: registered 16-bit add/subtract, or four independent signed 4-bit adds (PADDSB).
// Latency: one cycle. Inputs sampled at rising clk edge N appear on Sum/Ovfl after edge N.
// Backpressure: none. A new operation is accepted every cycle and there is no handshake.
//
// Ports:
//   clk   - rising-edge clock for the output registers
//   rst_n - asynchronous active-low reset; clears Sum and Ovfl
//   A, B  - 16-bit two's-complement operands
//   Sub   - word mode only: 1 = A-B, 0 = A+B (ignored when pad=1)
//   pad   - 0 = one 16-bit operation, 1 = four nibble-wise adds with no inter-nibble carry
//   Sum   - registered result
//   Ovfl  - registered signed-overflow flag (OR of the nibble flags in sub-word mode)
//
// Build option: define PSA_SAT_EN to saturate overflowing results instead of wrapping.
// Ovfl is the same in both builds.

module psa_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       c3,    // carry into bit 3, used for the overflow flag
    output logic       cout   // carry out of bit 3
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is derived directly from cin and the generate/propagate terms.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s  = p ^ c;
    assign c3 = c[3];
endmodule

module psa_16bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Sub,
    input  logic        pad,
    output logic [15:0] Sum,
    output logic        Ovfl
);
    // In sub-word mode Sub is ignored, so B is never inverted there.
    logic        do_sub;
    logic [15:0] b_eff;
    logic [15:0] raw_sum;
    logic [3:0]  blk_cin;
    logic [3:0]  blk_c3;
    logic [3:0]  blk_cout;
    logic [3:0]  nib_ovf;
    logic        word_ovf;

    logic [15:0] sum_d;
    logic [15:0] sum_q;
    logic        ovfl_d;
    logic        ovfl_q;

    assign do_sub = Sub & ~pad;
    assign b_eff  = do_sub ? ~B : B;

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_blk
            // The subtract "+1" enters at block 0. Block boundaries break the chain in sub-word mode.
            if (i == 0) begin : g_first
                assign blk_cin[i] = do_sub;
            end else begin : g_rest
                assign blk_cin[i] = blk_cout[i-1] & ~pad;
            end

            psa_cla4 u_cla (
                .a    (A[4*i +: 4]),
                .b    (b_eff[4*i +: 4]),
                .cin  (blk_cin[i]),
                .s    (raw_sum[4*i +: 4]),
                .c3   (blk_c3[i]),
                .cout (blk_cout[i])
            );

            assign nib_ovf[i] = blk_c3[i] ^ blk_cout[i];
        end
    endgenerate

    // The top block's bit-3 carries are bit 15's carries in word mode.
    assign word_ovf = nib_ovf[3];

    always_comb begin
        sum_d  = raw_sum;
        ovfl_d = pad ? (|nib_ovf) : word_ovf;
`ifdef PSA_SAT_EN
        // Overflow only happens when both addends share a sign, so the sign of A
        // gives the overflow direction: A negative means negative overflow.
        if (pad) begin
            for (int n = 0; n < 4; n++) begin
                if (nib_ovf[n]) begin
                    sum_d[4*n +: 4] = A[4*n+3] ? 4'h8 : 4'h7;
                end
            end
        end else if (word_ovf) begin
            sum_d = A[15] ? 16'h8000 : 16'h7FFF;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= 16'h0000;
            ovfl_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            ovfl_q <= ovfl_d;
        end
    end

    assign Sum  = sum_q;
    assign Ovfl = ovfl_q;
endmodule

// File: tb/tb_psa_16bit.sv
module tb_psa_16bit;
    logic        clk;
    logic        rst_n;
    logic [15:0] A;
    logic [15:0] B;
    logic        Sub;
    logic        pad;
    logic [15:0] Sum;
    logic        Ovfl;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] sum;
        logic        ovfl;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t pend;
    bit   pend_vld = 0;

    psa_16bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .Sub   (Sub),
        .pad   (pad),
        .Sum   (Sum),
        .Ovfl  (Ovfl)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on signed values.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic s, input logic p, input string tag);
        exp_t e;
        int   r;
        int   an;
        int   bn;
        e.tag  = tag;
        e.ovfl = 0;
        e.sum  = 0;
        if (!p) begin
            r = s ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
            if (r > 32767 || r < -32768) begin
                e.ovfl = 1;
`ifdef PSA_SAT_EN
                r = (r > 0) ? 32767 : -32768;
`endif
            end
            e.sum = r[15:0];
        end else begin
            for (int n = 0; n < 4; n++) begin
                an = (((a >> (4 * n)) & 15) >= 8) ? int'((a >> (4 * n)) & 15) - 16 : int'((a >> (4 * n)) & 15);
                bn = (((b >> (4 * n)) & 15) >= 8) ? int'((b >> (4 * n)) & 15) - 16 : int'((b >> (4 * n)) & 15);
                r = an + bn;
                if (r > 7 || r < -8) begin
                    e.ovfl = 1;
`ifdef PSA_SAT_EN
                    r = (r > 0) ? 7 : -8;
`endif
                end
                e.sum[4*n +: 4] = r[3:0];
            end
        end
        return e;
    endfunction

    function automatic void check(input string name, input logic [15:0] got_sum, input logic got_ovfl,
                                  input logic [15:0] exp_sum, input logic exp_ovfl);
        checks++;
        if (got_sum !== exp_sum || got_ovfl !== exp_ovfl) begin
            errors++;
            $display("FAIL %s: got Sum=%h Ovfl=%b, expected Sum=%h Ovfl=%b",
                     name, got_sum, got_ovfl, exp_sum, exp_ovfl);
        end
    endfunction

    // Model of the capture register: whatever inputs are pending at a live edge become an expected output.
    always @(posedge clk) begin
        if (rst_n && pend_vld) exp_q.push_back(pend);
    end

    // Reset discards any result that was in flight.
    always @(negedge rst_n) exp_q.delete();

    // Monitor: sample away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            check("reset_hold", Sum, Ovfl, 16'h0000, 1'b0);
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.tag, Sum, Ovfl, e.sum, e.ovfl);
        end
    end

    task automatic drive(input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic p, input string tag);
        @(posedge clk);
        #1;
        A = a; B = b; Sub = s; pad = p;
        pend = model(a, b, s, p, tag);
        pend_vld = 1;
    endtask

    initial begin
        rst_n = 0;
        A = 0; B = 0; Sub = 0; pad = 0;
        pend = model(0, 0, 0, 0, "idle");
        pend_vld = 1;
        #2;
        check("reset_state", Sum, Ovfl, 16'h0000, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1;

        // Directed vectors, including the overflow boundaries.
`ifdef PSA_SAT_EN
        drive(16'h0002, 16'h0010, 0, 0, "word_add");
        drive(16'h7FFF, 16'h0001, 0, 0, "word_add_ovf");
        drive(16'h8000, 16'h0001, 1, 0, "word_sub_ovf");
        drive(16'h7123, 16'h1111, 1, 1, "nib_pos_ovf");
        drive(16'h8F00, 16'hF0F0, 0, 1, "nib_neg_ovf");
`else
        drive(16'h0002, 16'h0010, 0, 0, "word_add");
        drive(16'h7FFF, 16'h0001, 0, 0, "word_add_ovf");
        drive(16'h8000, 16'h0001, 1, 0, "word_sub_ovf");
        drive(16'h7123, 16'h1111, 1, 1, "nib_pos_ovf");
        drive(16'h8F00, 16'hF0F0, 0, 1, "nib_neg_ovf");
`endif
        drive(16'h0000, 16'h8000, 1, 0, "word_sub_min");
        drive(16'hFFFF, 16'h0001, 0, 0, "word_carry_out");
        drive(16'h0FFF, 16'h0001, 0, 1, "nib_no_chain");
        drive(16'h8888, 16'h8888, 0, 1, "nib_all_neg");

        // Randomized back-to-back traffic with mode and Sub changing every cycle.
        for (int k = 0; k < 400; k++) begin
            drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), "random");
        end

        // Asynchronous reset in the middle of a cycle, then hold across edges.
        drive(16'h0002, 16'h0010, 0, 0, "pre_reset");
        @(posedge clk);
        #1 check("pre_reset_reg", Sum, Ovfl, 16'h0012, 1'b0);
        #1 rst_n = 0;
        #1 check("async_reset", Sum, Ovfl, 16'h0000, 1'b0);
        drive(16'h1234, 16'h0101, 1, 0, "after_release");
        @(posedge clk);
        #1 check("reset_across_edge", Sum, Ovfl, 16'h0000, 1'b0);
        @(negedge clk);
        #1 rst_n = 1;
        @(posedge clk);
        #1 check("release_capture", Sum, Ovfl, 16'h1133, 1'b0);

        for (int k = 0; k < 100; k++) begin
            drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), "random_post");
        end

        pend_vld = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results still expected, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
